prod_accumulator: RTL

Sequential accumulation stage directly downstream of the 4x4 array multiplier. It consumes the 8-bit unsigned product, adds it into a running accumulator under a valid/ready handshake, and counts accepted samples. On request, it emits a snapshot of the accumulator as two registered bytes, low byte first, on an 8-bit output bus. It is the first clocked stage after the combinational multiplier in the tile.

---
 rtl/prod_acc_pkg.sv | 13 +
 rtl/prod_accumulator_if.sv | 28 ++
 rtl/acc_adder.sv | 26 ++
 rtl/prod_accumulator.sv | 99 +++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// Shared types and widths for the product accumulator stage.
package prod_acc_pkg;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ACC,
        RD_LO,
        RD_HI
    } acc_state_e;

endpackage

// File: rtl/prod_accumulator_if.sv
// Product input handshake, clear, and two-byte readout bus of prod_accumulator.
interface prod_accumulator_if
    import prod_acc_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) ();

    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic              acc_clear;
    logic              rd_req;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  acc_count;
    logic              ovf;

    modport master (
        output prod_in, prod_valid, acc_clear, rd_req,
        input  prod_ready, rd_data, rd_valid, acc_count, ovf
    );

    modport slave (
        input  prod_in, prod_valid, acc_clear, rd_req,
        output prod_ready, rd_data, rd_valid, acc_count, ovf
    );

endinterface

// File: rtl/acc_adder.sv
// Accumulator plus zero-extended product, with carry-out.
// PROD_ACC_SAT_EN: clamp the sum to all-ones when the addition carries out.
module acc_adder
    import prod_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full;

    always_comb begin
        full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry = full[ACC_W];
`ifdef PROD_ACC_SAT_EN
        sum   = carry ? '1 : full[ACC_W-1:0];
`else
        sum   = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accumulator.sv
// Running accumulator of multiplier products with sample counter and two-byte readout.
// Overflow behaviour selected by PROD_ACC_SAT_EN (defined: saturate, else wrap).
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    prod_accumulator_if.slave  bus
);

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  snap_q, snap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              rd_valid_q, rd_valid_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;

    logic              accept;
    logic [ACC_W-1:0]  acc_base;
    logic [CNT_W-1:0]  cnt_base;
    logic [ACC_W-1:0]  sum;
    logic              carry;

    assign accept   = bus.prod_valid && (state_q == ACC);
    // Clear zeroes the adder operand so clear+accept lands exactly on the product.
    assign acc_base = bus.acc_clear ? '0 : acc_q;
    assign cnt_base = bus.acc_clear ? '0 : cnt_q;

    acc_adder #(
        .ACC_W (ACC_W)
    ) u_acc_adder (
        .acc   (acc_base),
        .prod  (bus.prod_in),
        .sum   (sum),
        .carry (carry)
    );

    always_comb begin
        acc_d   = accept ? sum : acc_base;
        cnt_d   = cnt_base;
        if (accept && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
        ovf_d   = (ovf_q && !bus.acc_clear) || (accept && carry);

        state_d = state_q;
        snap_d  = snap_q;
        case (state_q)
            ACC: begin
                if (bus.rd_req) begin
                    snap_d  = acc_d;
                    state_d = RD_LO;
                end
            end
            RD_LO:   state_d = RD_HI;
            RD_HI:   state_d = ACC;
            default: state_d = ACC;
        endcase

        rd_valid_d = (state_d != ACC);
        rd_data_d  = '0;
        if (state_d == RD_LO) begin
            rd_data_d = snap_d[BYTE_W-1:0];
        end else if (state_d == RD_HI) begin
            rd_data_d = BYTE_W'(snap_d >> BYTE_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACC;
            acc_q      <= '0;
            snap_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.prod_ready = (state_q == ACC);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.acc_count  = cnt_q;
    assign bus.ovf        = ovf_q;

endmodule
